// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg
// Types and helpers shared by the program-counter unit and its
// return-address stack.
//   pcState_e : FSM encoding (BOOT, RUN, HALT)
//   pcSrc_e   : next-PC source selected by the priority mux
//   alignMask : mask that clears the low log2(step) address bits
// ---------------------------------------------------------------------------
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pcState_e;

  typedef enum logic [2:0] {
    SRC_TRAP  = 3'd0,
    SRC_REDIR = 3'd1,
    SRC_RAS   = 3'd2,
    SRC_CALL  = 3'd3,
    SRC_SEQ   = 3'd4,
    SRC_HOLD  = 3'd5
  } pcSrc_e;

  // step is a power of two, so step-1 is exactly the set of offset bits
  // that must be zero in an aligned fetch address.
  function automatic logic [63:0] alignMask(input int unsigned step);
    logic [63:0] mask;
    mask = ~(64'(step) - 64'd1);
    return mask;
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// ---------------------------------------------------------------------------
// pc_unit_if
// Bundle between the PC unit and the rest of the front end.
//   fetch side : pc, pc_valid (from PC unit), fetch_ready, stall (to it)
//   control    : redirect_valid/redirect_target, trap, call/call_target,
//                ret, halt, resume (to PC unit)
//   status     : ras_empty, ras_full (from PC unit)
// master = the PC unit, slave = the environment driving the controls.
// ---------------------------------------------------------------------------
interface pc_unit_if #(
  parameter int WIDTH = 32
);
  import pc_pkg::*;

  logic             stall;
  logic             fetch_ready;
  logic             pc_valid;
  logic [WIDTH-1:0] pc;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_target;
  logic             trap;
  logic             call;
  logic [WIDTH-1:0] call_target;
  logic             ret;
  logic             halt;
  logic             resume;
  logic             ras_empty;
  logic             ras_full;

  modport master (
    input  stall, fetch_ready,
    input  redirect_valid, redirect_target,
    input  trap, call, call_target, ret, halt, resume,
    output pc_valid, pc, ras_empty, ras_full
  );

  modport slave (
    output stall, fetch_ready,
    output redirect_valid, redirect_target,
    output trap, call, call_target, ret, halt, resume,
    input  pc_valid, pc, ras_empty, ras_full
  );

endinterface

// File: rtl/pc_ras.sv
// ---------------------------------------------------------------------------
// pc_ras
// Return-address stack kept as a circular buffer.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write pushData above the current top
//   pop        : drop the top entry
//   replace    : overwrite the top entry with pushData (count unchanged)
//   clear      : forget every entry
//   pushData   : return address to store
//   topData    : current top entry (combinational read)
//   empty/full : count == 0 / count == RAS_DEPTH
// Priority when several strobes coincide: clear > push > replace > pop.
// ---------------------------------------------------------------------------
module pc_ras
  import pc_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             replace,
  input  logic             clear,
  input  logic [WIDTH-1:0] pushData,
  output logic [WIDTH-1:0] topData,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] stackMem [RAS_DEPTH];
  logic [PTR_W-1:0] topPtrReg;
  logic [PTR_W-1:0] topPtrNext;
  logic [PTR_W-1:0] wrPtr;
  logic [CNT_W-1:0] countReg;
  logic [CNT_W-1:0] countNext;
  logic             wrEn;

  always_comb begin
    topPtrNext = topPtrReg;
    countNext  = countReg;
    wrPtr      = topPtrReg;
    wrEn       = 1'b0;
    if (clear) begin
      topPtrNext = '0;
      countNext  = '0;
    end else if (push) begin
      // The pointer wraps freely, so a push onto a full stack lands on the
      // oldest entry; only the count saturates.
      topPtrNext = topPtrReg + PTR_W'(1);
      wrPtr      = topPtrNext;
      wrEn       = 1'b1;
      if (countReg != DEPTH_CNT) begin
        countNext = countReg + CNT_W'(1);
      end
    end else if (replace) begin
      wrEn = 1'b1;
    end else if (pop) begin
      if (countReg != '0) begin
        topPtrNext = topPtrReg - PTR_W'(1);
        countNext  = countReg - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      topPtrReg <= '0;
      countReg  <= '0;
    end else begin
      topPtrReg <= topPtrNext;
      countReg  <= countNext;
    end
  end

  // Entry contents need no reset: the count alone says which are live.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      stackMem[wrPtr] <= pushData;
    end
  end

  // The top must be usable in the same cycle a ret is seen, so the read
  // is combinational from the small array.
  assign topData = stackMem[topPtrReg];
  assign empty   = (countReg == '0);
  assign full    = (countReg == DEPTH_CNT);

endmodule

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
// Front-of-fetch program-counter generator.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (pc=RESET_VEC, BOOT, RAS empty)
//   bus   : pc_unit_if.master -- fetch handshake, redirect/trap/call/ret
//           controls, halt/resume, RAS status
// Next PC, highest priority first: trap, redirect, RAS pop on ret, call,
// sequential step, hold. Every loaded address is aligned to STEP and all
// outputs come straight from registers (one cycle latency).
// ---------------------------------------------------------------------------
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               STEP      = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] TRAP_VEC  = WIDTH'('h80),
  parameter int               RAS_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  pc_unit_if.master bus
);

  localparam logic [1:0] ST_BOOT = BOOT;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_HALT = HALT;

  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(alignMask(STEP));
  localparam logic [WIDTH-1:0] STEP_INC   = WIDTH'(STEP);

  logic [1:0]       stateReg;
  logic [1:0]       stateNext;
  logic [WIDTH-1:0] pcReg;
  logic [WIDTH-1:0] pcNext;
  logic [WIDTH-1:0] pcSeq;
  logic             pcValidReg;
  logic             adv;
  pcSrc_e           srcSel;

  logic             rasPush;
  logic             rasPop;
  logic             rasReplace;
  logic             rasClear;
  logic [WIDTH-1:0] rasTop;
  logic             rasEmpty;
  logic             rasFull;

  // pcValidReg is only set in RUN, so adv can never fire in BOOT or HALT.
  assign adv   = pcValidReg & bus.fetch_ready & ~bus.stall;
  // Natural wrap at 2^WIDTH; pcReg is always aligned so pcSeq is too.
  assign pcSeq = pcReg + STEP_INC;

  always_comb begin
    srcSel = SRC_HOLD;
    if (bus.trap) begin
      srcSel = SRC_TRAP;
    end else if (bus.redirect_valid) begin
      srcSel = SRC_REDIR;
    end else if (adv && bus.ret && !rasEmpty) begin
      srcSel = SRC_RAS;
    end else if (adv && bus.call) begin
      srcSel = SRC_CALL;
    end else if (adv) begin
      srcSel = SRC_SEQ;
    end
  end

  always_comb begin
    pcNext = pcReg;
    unique case (srcSel)
      SRC_TRAP:  pcNext = TRAP_VEC & ALIGN_MASK;
      SRC_REDIR: pcNext = bus.redirect_target & ALIGN_MASK;
      SRC_RAS:   pcNext = rasTop & ALIGN_MASK;
      SRC_CALL:  pcNext = bus.call_target & ALIGN_MASK;
      SRC_SEQ:   pcNext = pcSeq;
      default:   pcNext = pcReg;
    endcase
  end

  // A ret that coincides with a call turns the pop into a replace: the
  // caller's return address takes the slot just consumed.
  assign rasClear   = (srcSel == SRC_TRAP);
  assign rasPush    = (srcSel == SRC_CALL);
  assign rasPop     = (srcSel == SRC_RAS) && !bus.call;
  assign rasReplace = (srcSel == SRC_RAS) &&  bus.call;

  always_comb begin
    stateNext = stateReg;
    unique case (stateReg)
      ST_BOOT: stateNext = ST_RUN;
      ST_RUN: begin
        if (bus.halt && !bus.trap && !bus.redirect_valid) begin
          stateNext = ST_HALT;
        end
      end
      ST_HALT: begin
        if (bus.resume || bus.trap || bus.redirect_valid) begin
          stateNext = ST_RUN;
        end
      end
      default: stateNext = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg   <= ST_BOOT;
      pcReg      <= RESET_VEC;
      pcValidReg <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      pcReg      <= pcNext;
      pcValidReg <= (stateNext == ST_RUN);
    end
  end

  pc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) uRas (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (rasPush),
    .pop      (rasPop),
    .replace  (rasReplace),
    .clear    (rasClear),
    .pushData (pcSeq),
    .topData  (rasTop),
    .empty    (rasEmpty),
    .full     (rasFull)
  );

  assign bus.pc        = pcReg;
  assign bus.pc_valid  = pcValidReg;
  assign bus.ras_empty = rasEmpty;
  assign bus.ras_full  = rasFull;

endmodule

// File: tb/tb_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_unit
// Directed vectors for pc_unit with hand-computed expectations.
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, i.e. they show the effect of the edge just taken.
// ---------------------------------------------------------------------------
module tb_pc_unit;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  pc_unit_if #(.WIDTH(32)) bus ();

  pc_unit #(
    .WIDTH     (32),
    .STEP      (4),
    .RESET_VEC (32'h0000_0000),
    .TRAP_VEC  (32'h0000_0080),
    .RAS_DEPTH (4)
  ) dut (
    .clk   (clk),
    .rst_n (rstN),
    .bus   (bus)
  );

  int assertCount = 0;
  int failCount   = 0;

  task automatic checkVal(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic checkPc(input string tag, input logic [31:0] expPc,
                         input logic expValid);
    checkVal({tag, ".pc"}, bus.pc, expPc);
    checkVal({tag, ".valid"}, 32'(bus.pc_valid), 32'(expValid));
  endtask

  task automatic checkRas(input string tag, input logic expEmpty,
                          input logic expFull);
    checkVal({tag, ".empty"}, 32'(bus.ras_empty), 32'(expEmpty));
    checkVal({tag, ".full"}, 32'(bus.ras_full), 32'(expFull));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle redirect, then clear it.
  task automatic redirectTo(input logic [31:0] target);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = target;
    tick();
    bus.redirect_valid  = 1'b0;
  endtask

  logic [31:0] callTargets [5];
  logic [31:0] retExpect   [4];

  initial begin
    callTargets = '{32'h100, 32'h200, 32'h300, 32'h400, 32'h500};
    retExpect   = '{32'h404, 32'h304, 32'h204, 32'h104};

    bus.stall           = 1'b0;
    bus.fetch_ready     = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    bus.trap            = 1'b0;
    bus.call            = 1'b0;
    bus.call_target     = '0;
    bus.ret             = 1'b0;
    bus.halt            = 1'b0;
    bus.resume          = 1'b0;

    // Reset state, then sequential fetch.
    #12;
    checkPc("reset", 32'h0, 1'b0);
    checkRas("reset", 1'b1, 1'b0);
    rstN = 1'b1;
    tick();
    checkPc("boot_to_run", 32'h0, 1'b1);
    tick(); checkPc("seq1", 32'h4, 1'b1);
    tick(); checkPc("seq2", 32'h8, 1'b1);
    tick(); checkPc("seq3", 32'hC, 1'b1);

    // Stall and fetch_ready back-pressure.
    redirectTo(32'h10);
    checkPc("redir_0x10", 32'h10, 1'b1);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); checkVal($sformatf("stall_hold%0d", i), bus.pc, 32'h10);
    end
    bus.stall = 1'b0;
    tick(); checkVal("stall_release", bus.pc, 32'h14);
    bus.fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); checkVal($sformatf("notready_hold%0d", i), bus.pc, 32'h14);
    end
    bus.fetch_ready = 1'b1;
    tick(); checkVal("ready_release", bus.pc, 32'h18);

    // Trap beats redirect and clears a non-empty RAS.
    bus.call = 1'b1; bus.call_target = 32'h300;
    tick();
    bus.call = 1'b0;
    checkVal("call_0x300", bus.pc, 32'h300);
    checkRas("after_call", 1'b0, 1'b0);
    bus.trap = 1'b1;
    bus.redirect_valid = 1'b1; bus.redirect_target = 32'h203;
    tick();
    bus.trap = 1'b0; bus.redirect_valid = 1'b0;
    checkVal("trap_wins", bus.pc, 32'h80);
    checkRas("trap_clear", 1'b1, 1'b0);
    redirectTo(32'h203);
    checkVal("redir_aligned", bus.pc, 32'h200);

    // RAS overflow and drain.
    redirectTo(32'h0);
    checkVal("redir_0x0", bus.pc, 32'h0);
    bus.call = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.call_target = callTargets[i];
      tick(); checkVal($sformatf("call%0d", i), bus.pc, callTargets[i]);
    end
    bus.call = 1'b0;
    checkRas("ras_overflow", 1'b0, 1'b1);
    bus.ret = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); checkVal($sformatf("ret%0d", i), bus.pc, retExpect[i]);
    end
    checkRas("ras_drained", 1'b1, 1'b0);
    tick();
    checkVal("ret_empty_seq", bus.pc, 32'h108);
    checkRas("ret_empty", 1'b1, 1'b0);
    bus.ret = 1'b0;

    // Call and ret together.
    redirectTo(32'h1000);
    bus.call = 1'b1; bus.call_target = 32'h50;
    tick(); checkVal("call_0x50", bus.pc, 32'h50);
    bus.ret = 1'b1; bus.call_target = 32'h900;
    tick(); checkVal("callret_pc", bus.pc, 32'h1004);
    checkRas("callret", 1'b0, 1'b0);
    bus.call = 1'b0;
    tick(); checkVal("ret_replaced", bus.pc, 32'h54);
    checkRas("ret_replaced", 1'b1, 1'b0);
    bus.ret = 1'b0;

    // Halt / resume, wrap, trap out of HALT, reset in HALT.
    redirectTo(32'h40);
    bus.halt = 1'b1; bus.fetch_ready = 1'b0;
    tick();
    bus.halt = 1'b0; bus.fetch_ready = 1'b1;
    checkPc("halt", 32'h40, 1'b0);
    tick(); checkPc("halt_hold", 32'h40, 1'b0);
    bus.resume = 1'b1;
    tick();
    bus.resume = 1'b0;
    checkPc("resume", 32'h40, 1'b1);
    tick(); checkVal("resume_adv", bus.pc, 32'h44);
    redirectTo(32'hFFFF_FFFC);
    checkVal("top_addr", bus.pc, 32'hFFFF_FFFC);
    tick(); checkVal("wrap", bus.pc, 32'h0);
    bus.halt = 1'b1; bus.fetch_ready = 1'b0;
    tick();
    bus.halt = 1'b0; bus.fetch_ready = 1'b1;
    checkPc("halt2", 32'h0, 1'b0);
    bus.trap = 1'b1;
    tick();
    bus.trap = 1'b0;
    checkPc("trap_from_halt", 32'h80, 1'b1);
    bus.halt = 1'b1; bus.fetch_ready = 1'b0;
    tick();
    bus.halt = 1'b0;
    checkPc("halt3", 32'h80, 1'b0);
    #2 rstN = 1'b0;
    #1 checkPc("async_reset", 32'h0, 1'b0);
    checkRas("async_reset", 1'b1, 1'b0);
    bus.fetch_ready = 1'b1;
    tick(); checkPc("held_in_reset", 32'h0, 1'b0);
    #2 rstN = 1'b1;
    tick(); checkPc("reboot", 32'h0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
